// File: rtl/mem_stage_if.sv
// mem_stage_if: groups the memory-stage traffic into one bundle.
//   x_*    : instruction handed over from decode/execute (valid/ready)
//   dmem_* : request/grant/response data-memory port
//   wb_*   : retire port toward write-back, plus misalign_o pulse
// Modports:
//   slave  : the memory stage itself
//   master : the surrounding environment (upstream, memory, write-back)
interface mem_stage_if #(parameter int XLEN = 64);
  logic            x_valid_i;
  logic            x_ready_o;
  logic [XLEN-1:0] alu_result_i;
  logic [XLEN-1:0] store_data_i;
  logic [2:0]      funct3_i;
  logic [2:0]      op_type_i;
  logic [4:0]      rd_i;
  logic            rd_we_i;

  logic            dmem_req_o;
  logic            dmem_we_o;
  logic [XLEN-1:0] dmem_addr_o;
  logic [XLEN-1:0] dmem_wdata_o;
  logic [7:0]      dmem_be_o;
  logic            dmem_gnt_i;
  logic            dmem_rvalid_i;
  logic [XLEN-1:0] dmem_rdata_i;

  logic            wb_valid_o;
  logic            wb_we_o;
  logic [4:0]      wb_rd_o;
  logic [XLEN-1:0] wb_data_o;
  logic            misalign_o;

  modport slave (
    input  x_valid_i, alu_result_i, store_data_i, funct3_i, op_type_i, rd_i, rd_we_i,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
    output x_ready_o,
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
    output wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, misalign_o
  );

  modport master (
    output x_valid_i, alu_result_i, store_data_i, funct3_i, op_type_i, rd_i, rd_we_i,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
    input  x_ready_o,
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
    input  wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, misalign_o
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 64-bit RISC-V pipeline.
// Non-memory ops retire one cycle after accept; loads/stores are sequenced
// over the dmem request/grant/response port while x_ready_o stalls upstream.
// Ports:
//   clk_i   : clock, rising edge
//   reset_i : asynchronous active-high reset
//   bus     : mem_stage_if.slave (x_* upstream, dmem_* memory, wb_* retire)
//
// state | meaning
// IDLE  | ready for a new instruction; non-mem/bad accesses retire from here
// REQ   | dmem_req_o high, attributes held from latched registers until grant
// WAIT  | load granted, waiting for dmem_rvalid_i
module mem_stage #(
  parameter int XLEN = 64
) (
  input logic        clk_i,
  input logic        reset_i,
  mem_stage_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} stateT;

  stateT           state;
  logic [XLEN-1:0] addrQ;
  logic [XLEN-1:0] storeDataQ;
  logic [2:0]      funct3Q;
  logic            isStoreQ;
  logic [4:0]      rdQ;
  logic            rdWeQ;

  logic            wbValid;
  logic            wbWe;
  logic [4:0]      wbRd;
  logic [XLEN-1:0] wbData;
  logic            misalign;

  // Incoming access classification (from the x_* inputs, feeds registers only)
  logic            inIsLoad;
  logic            inIsStore;
  logic [2:0]      inSizeMask;
  logic            inBad;

  always_comb begin
    inIsLoad  = (bus.op_type_i == 3'd2);
    inIsStore = (bus.op_type_i == 3'd3);
    case (bus.funct3_i[1:0])
      2'b00:   inSizeMask = 3'b000;
      2'b01:   inSizeMask = 3'b001;
      2'b10:   inSizeMask = 3'b011;
      default: inSizeMask = 3'b111;
    endcase
    inBad = (bus.funct3_i == 3'b111)
         || (inIsStore && bus.funct3_i[2])
         || ((bus.alu_result_i[2:0] & inSizeMask) != 3'b000);
  end

  // dmem attributes decoded purely from latched registers
  logic [2:0]      offQ;
  logic [7:0]      beQ;
  logic [XLEN-1:0] wdataQ;

  assign offQ = addrQ[2:0];

  always_comb begin
    case (funct3Q[1:0])
      2'b00: begin
        beQ    = 8'b0000_0001 << offQ;
        wdataQ = {8{storeDataQ[7:0]}};
      end
      2'b01: begin
        beQ    = 8'b0000_0011 << offQ;
        wdataQ = {4{storeDataQ[15:0]}};
      end
      2'b10: begin
        beQ    = 8'b0000_1111 << offQ;
        wdataQ = {2{storeDataQ[31:0]}};
      end
      default: begin
        beQ    = 8'hFF;
        wdataQ = storeDataQ;
      end
    endcase
  end

  // Load lane extraction: move the addressed lane down to bit 0, then extend
  logic [XLEN-1:0] laneShifted;
  logic [XLEN-1:0] loadData;

  assign laneShifted = bus.dmem_rdata_i >> {offQ, 3'b000};

  always_comb begin
    case (funct3Q)
      3'b000:  loadData = {{56{laneShifted[7]}},  laneShifted[7:0]};
      3'b001:  loadData = {{48{laneShifted[15]}}, laneShifted[15:0]};
      3'b010:  loadData = {{32{laneShifted[31]}}, laneShifted[31:0]};
      3'b100:  loadData = {56'd0, laneShifted[7:0]};
      3'b101:  loadData = {48'd0, laneShifted[15:0]};
      3'b110:  loadData = {32'd0, laneShifted[31:0]};
      default: loadData = laneShifted;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state      <= IDLE;
      addrQ      <= '0;
      storeDataQ <= '0;
      funct3Q    <= '0;
      isStoreQ   <= 1'b0;
      rdQ        <= '0;
      rdWeQ      <= 1'b0;
      wbValid    <= 1'b0;
      wbWe       <= 1'b0;
      wbRd       <= '0;
      wbData     <= '0;
      misalign   <= 1'b0;
    end else begin
      wbValid  <= 1'b0;
      wbWe     <= 1'b0;
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.x_valid_i) begin
            addrQ      <= bus.alu_result_i;
            storeDataQ <= bus.store_data_i;
            funct3Q    <= bus.funct3_i;
            isStoreQ   <= inIsStore;
            rdQ        <= bus.rd_i;
            rdWeQ      <= bus.rd_we_i;
            if (!(inIsLoad || inIsStore)) begin
              wbValid <= 1'b1;
              wbWe    <= bus.rd_we_i && (bus.rd_i != 5'd0);
              wbRd    <= bus.rd_i;
              wbData  <= bus.alu_result_i;
            end else if (inBad) begin
              wbValid  <= 1'b1;
              wbRd     <= bus.rd_i;
              misalign <= 1'b1;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.dmem_gnt_i) begin
            if (isStoreQ) begin
              wbValid <= 1'b1;
              wbRd    <= rdQ;
              state   <= IDLE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.dmem_rvalid_i) begin
            wbValid <= 1'b1;
            wbWe    <= rdWeQ && (rdQ != 5'd0);
            wbRd    <= rdQ;
            wbData  <= loadData;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.x_ready_o    = (state == IDLE);
  assign bus.dmem_req_o   = (state == REQ);
  assign bus.dmem_we_o    = (state == REQ) && isStoreQ;
  assign bus.dmem_addr_o  = {addrQ[XLEN-1:3], 3'b000};
  assign bus.dmem_be_o    = beQ;
  assign bus.dmem_wdata_o = wdataQ;

  assign bus.wb_valid_o = wbValid;
  assign bus.wb_we_o    = wbWe;
  assign bus.wb_rd_o    = wbRd;
  assign bus.wb_data_o  = wbData;
  assign bus.misalign_o = misalign;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 64-bit RISC-V pipeline, directly downstream of the decode/execute stage. It consumes that stage's ALU result, rs2 store data, funct3 and instruction-type code. Loads and stores are sequenced over a request/grant/response data-memory port; all other instructions pass through with one cycle of latency. Retired results go to write-back, and `x_ready_o` stalls upstream while a memory access is outstanding.

## Interface
- `XLEN`, 64, datapath width; only 64 is supported.

- `clk_i` in 1: clock; all state updates on the rising edge.
- `reset_i` in 1: asynchronous, active-high reset.
- `x_valid_i` in 1: upstream presents an instruction.
- `x_ready_o` out 1: stage can accept; high only in IDLE.
- `alu_result_i` in 64: ALU result; this is the effective address for load/store.
- `store_data_i` in 64: rs2 value for stores.
- `funct3_i` in 3: size/sign code.
- `op_type_i` in 3: 0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JUMP/U; 6–7 are treated as 1.
- `rd_i` in 5: destination register.
- `rd_we_i` in 1: instruction writes rd.
- `dmem_req_o` out 1: memory request.
- `dmem_we_o` out 1: 1 = store.
- `dmem_addr_o` out 64: doubleword-aligned address, `{addr[63:3],3'b000}`.
- `dmem_wdata_o` out 64: lane-replicated store data.
- `dmem_be_o` out 8: byte enables.
- `dmem_gnt_i` in 1: request accepted this cycle.
- `dmem_rvalid_i` in 1: load data valid.
- `dmem_rdata_i` in 64: load doubleword.
- `wb_valid_o` out 1: one-cycle retire pulse.
- `wb_we_o` out 1: register-file write enable.
- `wb_rd_o` out 5: destination register.
- `wb_data_o` out 64: write-back data.
- `misalign_o` out 1: one-cycle pulse flagging a misaligned or illegal access.

## Operation
- FSM states: IDLE, REQ, WAIT.
- **IDLE**
  - Accept when `x_valid_i`; latch all inputs.
  - Non-memory op: next edge drives `wb_valid_o=1`, `wb_data_o=alu_result_i`, `wb_we_o=rd_we_i`, `wb_rd_o=rd_i`; stay in IDLE.
  - Aligned load/store: go to REQ.
- **Size from funct3**
  - 000/100 = byte.
  - 001/101 = half.
  - 010/110 = word.
  - 011 = double.
  - 111 = illegal. Stores with funct3 ≥ 100 are illegal.
- **Misaligned or illegal access**
  - Misaligned means `addr % size != 0`.
  - No memory request is made.
  - Next edge: `wb_valid_o=1`, `wb_we_o=0`, `misalign_o=1`; stay in IDLE.
- **REQ**
  - `dmem_req_o=1`, with address, `we`, `be` and `wdata` taken from latched registers and held stable until `dmem_gnt_i`.
  - On grant, store: retire next edge with `wb_valid_o=1`, `wb_we_o=0`; go to IDLE.
  - On grant, load: go to WAIT.
- **WAIT**
  - `dmem_req_o=0`.
  - On `dmem_rvalid_i`: extract lane at `off=addr[2:0]`, sign-extend (funct3 000/001/010) or zero-extend (100/101/110), then retire with `wb_we_o=rd_we_i`; go to IDLE.
- **Byte enables**
  - Byte: `be = 8'b1 << off`.
  - Half: `be = 8'b11 << off`.
  - Word: `be = 8'hF << off`.
  - Double: `be = 8'hFF`.
- **Store data**
  - `wdata` replicates the low byte/half/word across the 64-bit bus.
- **rd = x0**
  - `wb_we_o` is forced to 0.
- **Unexpected memory signals**
  - `dmem_rvalid_i` outside WAIT is ignored.
  - `dmem_gnt_i` outside REQ is ignored.

## Timing
- **Reset (asynchronous)**
  - State goes to IDLE.
  - `x_ready_o=1` combinationally from IDLE.
  - `dmem_req_o`, `wb_valid_o`, `wb_we_o` and `misalign_o` go to 0.
  - `wb_data_o`, `wb_rd_o` and the latched registers go to 0.
  - Reset mid-REQ/WAIT abandons the access: the request drops immediately, and a late `rvalid` is ignored.
- **Latency**
  - Non-memory op: retires 1 cycle after accept.
  - Store: 1 + g cycles, where g ≥ 1 is the cycle of grant.
  - Load: 1 + g + r cycles, where r ≥ 1 is the number of cycles from grant to `rvalid`. Zero-wait memory gives 3 cycles.
- **Throughput**
  - Non-memory ops: back-to-back, one per cycle.
  - `x_ready_o` stays low from the edge that enters REQ until the edge that returns to IDLE.
  - A new instruction may be accepted on the same edge the memory op retires.
- **Outputs**
  - All `wb_*` and `misalign_o` are registered.
  - `dmem_*` are decoded from registered state only; there is no combinational path from `x_*` inputs.

## Test plan
- Reset mid-WAIT, then `rvalid` arrives → no `wb_valid_o`, state is IDLE, `x_ready_o=1`.
- Three R-type ops back-to-back with `alu_result_i` 5, 6, 7 → `wb_valid_o` high 3 consecutive cycles with `wb_data_o` 5, 6, 7; `x_ready_o` stays 1.
- SB at address 0x1003 with `store_data_i` 0xAB, grant delayed 2 cycles → `dmem_addr_o` 0x1000, `dmem_be_o` 0x08, `dmem_wdata_o` 0xABABABABABABABAB held for 3 cycles; retire with `wb_we_o=0`.
- LH at 0x2006 with `rdata` 0x8001_0000_0000_0000, then LHU at the same address → `wb_data_o` 0xFFFFFFFFFFFF8001, then 0x8001.
- LW at 0x3002 → no `dmem_req_o`; next cycle `misalign_o=1`, `wb_valid_o=1`, `wb_we_o=0`.
- LD to x0 at 0x4000 with zero-wait memory → `wb_valid_o` 3 cycles after accept with `wb_we_o=0`; a stray `rvalid` during REQ is ignored.
